fp_add_arb2_ctrl: RTL and testbench

FP_ADD_ARB2_CTRL -- requirements
Module: fp_add_arb2_ctrl

---
 rtl/fp_add_arb_pkg.sv | 18 +
 rtl/fp_add_arb_rspbuf.sv | 35 +++
 rtl/fp_add_arb2_ctrl.sv | 125 ++++++++++++
 tb/tb_fp_add_arb2_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_arb_pkg.sv
// Shared types for the two-requester E8M23 adder front end.
// Tag pipe entries track which requester owns each in-flight add.
package fp_add_arb_pkg;

    localparam int LAT_DEF = 1;
    localparam int SIGN_W  = 1;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int FP_W    = SIGN_W + EXP_W + MAN_W;

    typedef logic [0:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } stage_t;

endpackage

// File: rtl/fp_add_arb_rspbuf.sv
// One-entry valid/ready result holder per requester.
// Accepts a fill in the same cycle its current entry is popped.
module fp_add_arb_rspbuf
    import fp_add_arb_pkg::*;
(
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_data
);

    logic fill;

    assign in_ready = !out_valid || out_ready;
    assign fill     = in_valid && in_ready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (fill) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_add_arb2_ctrl.sv
// Round-robin sharing of one pipelined E8M23 adder by two requesters.
// A tag pipe mirrors the adder stages and steers each result home.
module fp_add_arb2_ctrl
    import fp_add_arb_pkg::*;
#(
    parameter int LAT = LAT_DEF
)
(
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [FP_W-1:0]  req0_a,
    input  logic [FP_W-1:0]  req0_b,
    input  logic [2:0]       req0_rm,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [FP_W-1:0]  req1_a,
    input  logic [FP_W-1:0]  req1_b,
    input  logic [2:0]       req1_rm,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [FP_W-1:0]  rsp0_x,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [FP_W-1:0]  rsp1_x,
    output logic             fpu_a_sign,
    output logic [EXP_W-1:0] fpu_a_exp,
    output logic [MAN_W-1:0] fpu_a_man,
    output logic             fpu_b_sign,
    output logic [EXP_W-1:0] fpu_b_exp,
    output logic [MAN_W-1:0] fpu_b_man,
    output logic [2:0]       fpu_rm,
    input  logic [FP_W-1:0]  fpu_x,
    output logic             fpu_stall,
    output logic             busy
);

    stage_t          stg [LAT];
    stage_t          head;
    logic [LAT-1:0]  stg_v;
    logic            ptr;
    logic            grant0;
    logic            grant1;
    logic            issue;
    logic [1:0]      buf_in_valid;
    logic [1:0]      buf_in_ready;
    logic [FP_W-1:0] op_a;
    logic [FP_W-1:0] op_b;

    // ptr=0 favours req0 when both ask
    assign grant0 = req0_valid && (!req1_valid || !ptr);
    assign grant1 = req1_valid && (!req0_valid || ptr);

    assign req0_ready = grant0 && !fpu_stall;
    assign req1_ready = grant1 && !fpu_stall;
    assign issue      = (req0_valid && req0_ready) ||
                        (req1_valid && req1_ready);

    assign head      = stg[LAT-1];
    assign fpu_stall = head.valid && !buf_in_ready[head.tag];

    assign buf_in_valid[0] = head.valid && (head.tag == 1'b0);
    assign buf_in_valid[1] = head.valid && (head.tag == 1'b1);

    always_comb begin
        op_a   = '0;
        op_b   = '0;
        fpu_rm = '0;
        if (grant0) begin
            op_a   = req0_a;
            op_b   = req0_b;
            fpu_rm = req0_rm;
        end else if (grant1) begin
            op_a   = req1_a;
            op_b   = req1_b;
            fpu_rm = req1_rm;
        end
    end

    assign {fpu_a_sign, fpu_a_exp, fpu_a_man} = op_a;
    assign {fpu_b_sign, fpu_b_exp, fpu_b_man} = op_b;

    always_comb begin
        stg_v = '0;
        for (int i = 0; i < LAT; i++) stg_v[i] = stg[i].valid;
    end

    assign busy = (|stg_v) || rsp0_valid || rsp1_valid;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < LAT; i++) stg[i] <= '0;
            ptr <= 1'b0;
        end else if (!fpu_stall) begin
            stg[0].valid <= issue;
            stg[0].tag   <= tag_t'(grant1);
            for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
            if (issue) ptr <= grant0;
        end
    end

    fp_add_arb_rspbuf u_rspbuf0 (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (buf_in_valid[0]),
        .in_ready  (buf_in_ready[0]),
        .in_data   (fpu_x),
        .out_valid (rsp0_valid),
        .out_ready (rsp0_ready),
        .out_data  (rsp0_x)
    );

    fp_add_arb_rspbuf u_rspbuf1 (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (buf_in_valid[1]),
        .in_ready  (buf_in_ready[1]),
        .in_data   (fpu_x),
        .out_valid (rsp1_valid),
        .out_ready (rsp1_ready),
        .out_data  (rsp1_x)
    );

endmodule

// File: tb/tb_fp_add_arb2_ctrl.sv
// Directed bench for fp_add_arb2_ctrl at LAT=1 with a registered adder model.
// Operands are small integers so every sum is exact and hand-checkable.
module tb_fp_add_arb2_ctrl;

    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F4  = 32'h40800000;
    localparam logic [31:0] F5  = 32'h40A00000;
    localparam logic [31:0] F6  = 32'h40C00000;
    localparam logic [31:0] F7  = 32'h40E00000;
    localparam logic [31:0] F8  = 32'h41000000;
    localparam logic [31:0] F9  = 32'h41100000;
    localparam logic [31:0] F10 = 32'h41200000;
    localparam logic [31:0] F11 = 32'h41300000;
    localparam logic [31:0] F12 = 32'h41400000;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_rm, req1_rm;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_x, rsp1_x;
    logic        fpu_a_sign, fpu_b_sign;
    logic [7:0]  fpu_a_exp, fpu_b_exp;
    logic [22:0] fpu_a_man, fpu_b_man;
    logic [2:0]  fpu_rm;
    logic [31:0] fpu_x;
    logic        fpu_stall, busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_stall = 0;
    logic [31:0] got0[$];
    logic [31:0] got1[$];

    always #5 aclk = ~aclk;

    fp_add_arb2_ctrl #(.LAT(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_rm(req0_rm),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_rm(req1_rm),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_x(rsp0_x),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_x(rsp1_x),
        .fpu_a_sign(fpu_a_sign), .fpu_a_exp(fpu_a_exp), .fpu_a_man(fpu_a_man),
        .fpu_b_sign(fpu_b_sign), .fpu_b_exp(fpu_b_exp), .fpu_b_man(fpu_b_man),
        .fpu_rm(fpu_rm), .fpu_x(fpu_x), .fpu_stall(fpu_stall), .busy(busy)
    );

    // Single-to-double widening; only normal numbers and zero are used
    function automatic real s2r(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:0] == 31'd0) d = {s[31], 63'd0};
        else d = {s[31], {3'b000, s[30:23]} + 11'd896, s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    always @(posedge aclk) begin
        if (!aresetn) fpu_x <= '0;
        else if (!fpu_stall)
            fpu_x <= r2s(s2r({fpu_a_sign, fpu_a_exp, fpu_a_man}) +
                         s2r({fpu_b_sign, fpu_b_exp, fpu_b_man}));
    end

    always @(negedge aclk) begin
        if (aresetn && rsp0_valid && rsp0_ready) got0.push_back(rsp0_x);
        if (aresetn && rsp1_valid && rsp1_ready) got1.push_back(rsp1_x);
        if (fpu_stall) n_stall++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    logic [31:0] a0 [4];
    logic [31:0] a1 [4];
    logic [31:0] e0 [4];
    logic [31:0] e1 [4];

    initial begin
        int i0, i1;
        a0 = '{F1, F2, F3, F4};
        e0 = '{F2, F3, F4, F5};
        a1 = '{F8, F9, F10, F11};
        e1 = '{F9, F10, F11, F12};

        aresetn = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_rm = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_rm = 0;
        rsp0_ready = 1; rsp1_ready = 1;
        tick();
        tick();

        chk("rst_v0", rsp0_valid, 0);
        chk("rst_v1", rsp1_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", fpu_stall, 0);
        chk("rst_x0", rsp0_x, 0);
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rst_rdy0", req0_ready, 1);
        chk("rst_rdy1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        aresetn = 1;

        // single add: 1.0 + 2.0
        req0_valid = 1; req0_a = F1; req0_b = F2; req0_rm = 0;
        #1;
        chk("t20_rdy", req0_ready, 1);
        chk("t20_aexp", fpu_a_exp, 8'h7F);
        chk("t20_bexp", fpu_b_exp, 8'h80);
        tick();
        req0_valid = 0;
        #1;
        chk("t20_nogrant", {fpu_a_sign, fpu_a_exp, fpu_a_man}, 0);
        chk("t20_v_early", rsp0_valid, 0);
        chk("t20_busy", busy, 1);
        tick();
        chk("t20_v", rsp0_valid, 1);
        chk("t20_x", rsp0_x, F3);
        tick();
        chk("t20_pop", rsp0_valid, 0);
        chk("t20_idle", busy, 0);

        // round-robin with both requesters asking
        do_reset();
        got0.delete(); got1.delete();
        n_stall = 0;
        i0 = 0; i1 = 0;
        req0_b = F1; req1_b = F1; req0_rm = 3'd3; req1_rm = 3'd6;
        for (int i = 0; i < 8; i++) begin
            req0_valid = (i0 < 4);
            req1_valid = (i1 < 4);
            if (i0 < 4) req0_a = a0[i0];
            if (i1 < 4) req1_a = a1[i1];
            #1;
            chk($sformatf("t21_g0_%0d", i), req0_ready, (i % 2 == 0));
            chk($sformatf("t21_g1_%0d", i), req1_ready, (i % 2 == 1));
            if (i == 0) chk("t21_rm", fpu_rm, 3'd3);
            if (req0_valid && req0_ready) i0++;
            if (req1_valid && req1_ready) i1++;
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        repeat (4) tick();
        chk("t21_n0", got0.size(), 4);
        chk("t21_n1", got1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t21_r0_%0d", i),
                (i < got0.size()) ? got0[i] : 32'hxxxxxxxx, e0[i]);
            chk($sformatf("t21_r1_%0d", i),
                (i < got1.size()) ? got1[i] : 32'hxxxxxxxx, e1[i]);
        end
        chk("t21_nostall", n_stall, 0);

        // rsp0 backpressure stalls the adder
        got0.delete();
        rsp0_ready = 0;
        req0_valid = 1; req0_a = F5; req0_b = F1;
        #1;
        chk("t22_r1", req0_ready, 1);
        tick();
        req0_a = F6;
        #1;
        chk("t22_r2", req0_ready, 1);
        chk("t22_nostall", fpu_stall, 0);
        tick();
        req0_a = F7; req1_valid = 1; req1_a = F2; req1_b = F1;
        #1;
        chk("t22_stall", fpu_stall, 1);
        chk("t22_rdy0", req0_ready, 0);
        chk("t22_rdy1", req1_ready, 0);
        chk("t22_x", rsp0_x, F6);
        tick();
        chk("t22_hold_x", rsp0_x, F6);
        chk("t22_hold_st", fpu_stall, 1);
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1;
        #1;
        chk("t22_clr", fpu_stall, 0);
        tick();
        chk("t22_fill_v", rsp0_valid, 1);
        chk("t22_fill_x", rsp0_x, F7);
        tick();
        chk("t22_done", rsp0_valid, 0);
        chk("t22_n", got0.size(), 2);
        chk("t22_o0", (got0.size() > 0) ? got0[0] : 32'hxxxxxxxx, F6);
        chk("t22_o1", (got0.size() > 1) ? got0[1] : 32'hxxxxxxxx, F7);

        // one-cycle rsp1 backpressure with a result waiting
        got1.delete();
        req1_valid = 1; req1_a = F2; req1_b = F1;
        tick();
        req1_a = F3;
        tick();
        req1_valid = 0; rsp1_ready = 0; n_stall = 0;
        #1;
        chk("t23_stall", fpu_stall, 1);
        chk("t23_x", rsp1_x, F3);
        tick();
        rsp1_ready = 1;
        #1;
        chk("t23_clr", fpu_stall, 0);
        chk("t23_x_hold", rsp1_x, F3);
        tick();
        chk("t23_fill_v", rsp1_valid, 1);
        chk("t23_fill_x", rsp1_x, F4);
        tick();
        chk("t23_done", rsp1_valid, 0);
        chk("t23_nstall", n_stall, 1);
        chk("t23_n", got1.size(), 2);
        chk("t23_o1", (got1.size() > 1) ? got1[1] : 32'hxxxxxxxx, F4);

        // reset with one result held and one at the head
        got0.delete(); got1.delete();
        rsp0_ready = 0;
        req0_valid = 1; req0_a = F9; req0_b = F1;
        tick();
        req0_a = F10;
        tick();
        req0_valid = 0;
        #1;
        chk("t24_pre_busy", busy, 1);
        chk("t24_pre_v0", rsp0_valid, 1);
        aresetn = 0;
        tick();
        chk("t24_v0", rsp0_valid, 0);
        chk("t24_v1", rsp1_valid, 0);
        chk("t24_busy", busy, 0);
        chk("t24_stall", fpu_stall, 0);
        chk("t24_x0", rsp0_x, 0);
        aresetn = 1; req0_valid = 1; req1_valid = 1;
        #1;
        chk("t24_ptr0", req0_ready, 1);
        chk("t24_ptr1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1;
        repeat (4) tick();
        chk("t24_late0", got0.size(), 0);
        chk("t24_late1", got1.size(), 0);
        chk("t24_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
